// File: rtl/tx_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_pkg
//  Description : Shared types and constants for the TX framing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_frame_pkg;

    // Framing controller states
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        R_SYNC = 4'd1,
        R_LEN  = 4'd2,
        R_WAIT = 4'd3,
        R_BYTE = 4'd4,
        R_CSUM = 4'd5,
        A_SYNC = 4'd6,
        A_CODE = 4'd7,
        A_INV  = 4'd8
    } tx_state_t;

    // Default sync bytes
    localparam logic [7:0] DEF_RES_SYNC = 8'hA5;
    localparam logic [7:0] DEF_ACK_SYNC = 8'h5A;

    // Sync + length/code bytes ahead of any frame body
    localparam int FRAME_HDR_BYTES = 2;

endpackage : tx_frame_pkg
`default_nettype wire

// File: rtl/tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_ctrl
//  Description : Arbitrates result and ack frames onto one byte stream,
//                serializes result words LSB byte first, appends an XOR
//                checksum and writes bytes into the output FIFO when not full.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int         WORD_W   = 32,
    parameter logic [7:0] RES_SYNC = DEF_RES_SYNC,
    parameter logic [7:0] ACK_SYNC = DEF_ACK_SYNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_req,
    input  logic [7:0]        res_len,
    output logic              res_grant,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    input  logic              ack_req,
    input  logic [7:0]        ack_code,
    output logic              ack_grant,
    output logic              busy,
    output logic              fifo_set,
    output logic [7:0]        fifo_data,
    input  logic              fifo_full
);

    localparam int WORD_BYTES = WORD_W / 8;
    localparam int BIDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(WORD_BYTES - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              last_ack;
    logic [7:0]        len_r;
    logic [7:0]        code_r;
    logic [7:0]        csum;
    logic [7:0]        words_left;
    logic [BIDX_W-1:0] byte_idx;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] shift_nxt;
    logic              emit;
    logic              wr;

    // fifo_data always holds the byte of the current emit state, so the
    // strobe can be decoded combinationally while the data stays registered.
    assign emit       = (state == R_SYNC) || (state == R_LEN) || (state == R_BYTE) ||
                        (state == R_CSUM) || (state == A_SYNC) || (state == A_CODE) ||
                        (state == A_INV);
    assign fifo_set   = emit && !fifo_full;
    assign wr         = fifo_set;
    assign word_ready = (state == R_WAIT);
    assign shift_nxt  = shift >> 8;

    // Next-state decode: arbitration in IDLE, emit states advance only on a write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ack_req && (!res_req || !last_ack)) state_nxt = A_SYNC;
                else if (res_req)                       state_nxt = R_SYNC;
            end
            R_SYNC: if (wr) state_nxt = R_LEN;
            R_LEN:  if (wr) state_nxt = (len_r == 8'd0) ? R_CSUM : R_WAIT;
            R_WAIT: if (word_valid) state_nxt = R_BYTE;
            R_BYTE: begin
                if (wr && (byte_idx == LAST_IDX))
                    state_nxt = (words_left != 8'd0) ? R_WAIT : R_CSUM;
            end
            R_CSUM: if (wr) state_nxt = IDLE;
            A_SYNC: if (wr) state_nxt = A_CODE;
            A_CODE: if (wr) state_nxt = A_INV;
            A_INV:  if (wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grants, byte pipeline, checksum and word/byte counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_ack   <= 1'b0;
            busy       <= 1'b0;
            res_grant  <= 1'b0;
            ack_grant  <= 1'b0;
            fifo_data  <= 8'd0;
            len_r      <= 8'd0;
            code_r     <= 8'd0;
            csum       <= 8'd0;
            words_left <= 8'd0;
            byte_idx   <= '0;
            shift      <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            res_grant <= 1'b0;
            ack_grant <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == A_SYNC) begin
                        ack_grant <= 1'b1;
                        code_r    <= ack_code;
                        csum      <= 8'd0;
                        fifo_data <= ACK_SYNC;
                    end else if (state_nxt == R_SYNC) begin
                        res_grant <= 1'b1;
                        len_r     <= res_len;
                        csum      <= 8'd0;
                        fifo_data <= RES_SYNC;
                    end
                end
                R_SYNC: if (wr) fifo_data <= len_r;
                R_LEN: begin
                    if (wr) begin
                        csum       <= csum ^ len_r;
                        words_left <= len_r;
                        // Empty frame: checksum is just the length byte
                        if (len_r == 8'd0) fifo_data <= csum ^ len_r;
                    end
                end
                R_WAIT: begin
                    if (word_valid) begin
                        shift      <= word_data;
                        fifo_data  <= word_data[7:0];
                        words_left <= words_left - 8'd1;
                        byte_idx   <= '0;
                    end
                end
                R_BYTE: begin
                    if (wr) begin
                        csum     <= csum ^ fifo_data;
                        shift    <= shift_nxt;
                        byte_idx <= byte_idx + 1'b1;
                        // After the last byte of the last word, stage the checksum
                        fifo_data <= (byte_idx == LAST_IDX) ? (csum ^ fifo_data)
                                                            : shift_nxt[7:0];
                    end
                end
                R_CSUM: if (wr) last_ack <= 1'b0;
                A_SYNC: if (wr) fifo_data <= code_r;
                A_CODE: if (wr) fifo_data <= ~code_r;
                A_INV:  if (wr) last_ack <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule : tx_frame_ctrl
`default_nettype wire

// File: tb/tb_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_frame_ctrl
//  Description : Scoreboard bench for tx_frame_ctrl. A frame-level model
//                predicts byte streams and arbitration order; a monitor pops
//                and compares each FIFO write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_ctrl;
    import tx_frame_pkg::*;

    localparam int WORD_W = 32;
    localparam int WB     = WORD_W / 8;
    localparam int BOUND  = 2000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              res_req = 1'b0;
    logic [7:0]        res_len = 8'd0;
    logic              res_grant;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              ack_req = 1'b0;
    logic [7:0]        ack_code = 8'd0;
    logic              ack_grant;
    logic              busy;
    logic              fifo_set;
    logic [7:0]        fifo_data;
    logic              fifo_full;

    tx_frame_ctrl #(.WORD_W(WORD_W), .RES_SYNC(8'hA5), .ACK_SYNC(8'h5A)) dut (
        .clk(clk), .rst(rst),
        .res_req(res_req), .res_len(res_len), .res_grant(res_grant),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .ack_req(ack_req), .ack_code(ack_code), .ack_grant(ack_grant),
        .busy(busy), .fifo_set(fifo_set), .fifo_data(fifo_data), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    logic [7:0]        exp_q[$];
    logic [WORD_W-1:0] word_q[$];
    int n_cmp = 0, n_fail = 0, n_writes = 0;
    bit m_last_ack = 1'b0;
    bit rand_full = 1'b0, force_full = 1'b0, rand_valid = 1'b0, wr_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: byte sequences straight from the frame format
    function automatic void push_ack(input logic [7:0] code);
        exp_q.push_back(8'h5A);
        exp_q.push_back(code);
        exp_q.push_back(~code);
    endfunction

    function automatic void push_res(input logic [WORD_W-1:0] words[$]);
        logic [7:0] cs, b, len8;
        len8 = 8'(words.size());
        exp_q.push_back(8'hA5);
        exp_q.push_back(len8);
        cs = len8;
        foreach (words[i]) begin
            for (int j = 0; j < WB; j++) begin
                b = words[i][8*j +: 8];
                exp_q.push_back(b);
                cs ^= b;
            end
        end
        exp_q.push_back(cs);
    endfunction

    // Monitor: pop/compare each written byte, no writes while full
    always @(negedge clk) begin
        if (rst) begin
            if (word_ready) wr_seen = 1'b1;
            if (fifo_full) check("set_while_full", {31'd0, fifo_set}, 32'd0);
            if (fifo_set) begin
                n_writes++;
                if (exp_q.size() == 0) check("unexpected_byte", {24'd0, fifo_data}, 32'hFFFF_FFFF);
                else check("byte", {24'd0, fifo_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Word source: presents queued words, optionally with random gaps
    initial begin
        bit hs;
        word_valid = 1'b0;
        word_data  = '0;
        forever begin
            @(negedge clk);
            hs = word_valid && word_ready;
            @(posedge clk);
            #1;
            if (hs && word_q.size() > 0) void'(word_q.pop_front());
            word_valid = 1'b0;
            if (word_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                word_valid = 1'b1;
                word_data  = word_q[0];
            end
        end
    end

    // FIFO back-pressure: forced window or random
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            fifo_full = force_full || (rand_full && ($urandom_range(0, 3) == 0));
        end
    end

    task automatic wait_writes(input int target);
        int k = 0;
        while (n_writes < target && k < BOUND) begin
            @(posedge clk);
            k++;
        end
        check("wait_writes_timeout", {31'd0, (k >= BOUND)}, 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_fifo_set"},   {31'd0, fifo_set},   32'd0);
        check({tag, "_fifo_data"},  {24'd0, fifo_data},  32'd0);
        check({tag, "_word_ready"}, {31'd0, word_ready}, 32'd0);
        check({tag, "_res_grant"},  {31'd0, res_grant},  32'd0);
        check({tag, "_ack_grant"},  {31'd0, ack_grant},  32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
    endtask

    // Issue one scenario (result and/or ack request) and wait for it to finish
    task automatic run_frame(input bit do_res, input bit do_ack, input logic [7:0] code,
                             input logic [WORD_W-1:0] words[$],
                             output int t_grant, output int t_end);
        bit ack_first;
        int n = 0, g_res = 0, g_ack = 0, first = -1;
        ack_first = do_ack && (!do_res || !m_last_ack);
        if (ack_first) push_ack(code);
        if (do_res) begin
            push_res(words);
            foreach (words[i]) word_q.push_back(words[i]);
        end
        if (do_ack && !ack_first) push_ack(code);
        m_last_ack = do_ack && !(do_res && ack_first);
        res_len  = 8'(words.size());
        ack_code = code;
        res_req  = do_res;
        ack_req  = do_ack;
        t_grant  = -1;
        t_end    = -1;
        while ((res_req || ack_req || busy) && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (res_grant) begin
                g_res++; res_req = 1'b0;
                if (first < 0) first = 0;
                if (t_grant < 0) t_grant = n;
            end
            if (ack_grant) begin
                g_ack++; ack_req = 1'b0;
                if (first < 0) first = 1;
                if (t_grant < 0) t_grant = n;
            end
            if (!res_req && !ack_req && !busy) t_end = n;
        end
        check("frame_timeout", {31'd0, (n >= BOUND)}, 32'd0);
        res_req = 1'b0;
        ack_req = 1'b0;
        check("res_grant_count", g_res, {31'd0, do_res});
        check("ack_grant_count", g_ack, {31'd0, do_ack});
        if (do_res && do_ack) check("tie_order", first, ack_first ? 32'd1 : 32'd0);
        check("bytes_outstanding", exp_q.size(), 32'd0);
        check("words_outstanding", word_q.size(), 32'd0);
        exp_q.delete();
        word_q.delete();
    endtask

    initial begin
        logic [WORD_W-1:0] wq[$];
        int tg, te, s, k;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Tie out of reset: ack first
        wq = {32'hDEADBEEF};
        run_frame(1'b1, 1'b1, 8'h77, wq, tg, te);

        // Ack only, unstalled: three writes then idle
        wq.delete();
        run_frame(1'b0, 1'b1, 8'h3C, wq, tg, te);
        check("ack_frame_cycles", te - tg, 32'd3);

        // Tie after an ack was served last: result first
        wq = {32'h0BADF00D, 32'h12345678};
        run_frame(1'b1, 1'b1, 8'hE1, wq, tg, te);

        // len=1 with a 5-cycle full stall after byte 33
        wq = {32'h11223344};
        s = n_writes;
        fork
            run_frame(1'b1, 1'b0, 8'h00, wq, tg, te);
            begin
                int s2;
                wait_writes(s + 4);
                #1 force_full = 1'b1;
                s2 = n_writes;
                repeat (5) @(posedge clk);
                #1;
                check("stall_writes", n_writes - s2, 32'd0);
                check("stall_held_byte", {24'd0, fifo_data}, 32'h22);
                force_full = 1'b0;
            end
        join

        // len=2 boundary words
        wq = {32'h00000001, 32'h80000000};
        run_frame(1'b1, 1'b0, 8'h00, wq, tg, te);

        // len=0: no payload, word_ready never asserted
        wq.delete();
        wr_seen = 1'b0;
        run_frame(1'b1, 1'b0, 8'h00, wq, tg, te);
        check("len0_word_ready_seen", {31'd0, wr_seen}, 32'd0);

        // Reset mid-payload
        wq = {32'hCAFEF00D, 32'h12345678};
        s = n_writes;
        push_res(wq);
        foreach (wq[i]) word_q.push_back(wq[i]);
        res_len = 8'd2;
        res_req = 1'b1;
        k = 0;
        while (!res_grant && k < BOUND) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mid_reset_grant_timeout", {31'd0, (k >= BOUND)}, 32'd0);
        res_req = 1'b0;
        wait_writes(s + 5);
        #3 rst = 1'b0;
        #1;
        check_reset_outs("mid_reset");
        exp_q.delete();
        word_q.delete();
        m_last_ack = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomized traffic with back-pressure and word gaps
        rand_full  = 1'b1;
        rand_valid = 1'b1;
        repeat (40) begin
            int kind, len;
            kind = $urandom_range(0, 2);
            len  = $urandom_range(0, 4);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back($urandom);
            run_frame(kind != 0, kind != 1, 8'($urandom), wq, tg, te);
        end
        rand_full  = 1'b0;
        rand_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tx_frame_ctrl
`default_nettype wire
